// File: rtl/relm_io_pkg.sv
// Shared ReLM IO definitions: serial FSM state encoding and command/status bit
// positions, given as offsets below the top data bit (WD) of pop_d/pop_q.
package relm_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_st_e;

  // pop_d strobes sit at bit WD-<offset>
  localparam int CMD_TX_WR   = 1;
  localparam int CMD_RX_POP  = 2;
  localparam int CMD_ERR_CLR = 3;

  // pop_q flags sit at bit WD-<offset>
  localparam int STS_TX_RDY  = 1;
  localparam int STS_RX_VLD  = 2;
  localparam int STS_OVR     = 3;
  localparam int STS_FERR    = 4;

endpackage

// File: rtl/relm_fifo.sv
// Codebase FIFO: 2**WAD entries, head visible combinationally, a write into a
// full FIFO is accepted only when a read completes in the same cycle.
module relm_fifo #(
  parameter int WAD = 4,
  parameter int WD  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_in,
  input  logic          wr_en,
  input  logic [WD-1:0] wr_data,
  input  logic          rd_en,
  output logic [WD-1:0] rd_data,
  output logic          empty,
  output logic          full
);

  localparam logic [WAD:0]   DEPTH   = (WAD+1)'(2**WAD);
  localparam logic [WAD-1:0] PTR_ONE = 1;

  logic [WD-1:0]  mem [2**WAD];
  logic [WAD-1:0] wp, rp;
  logic [WAD:0]   count;
  logic           do_rd, do_wr;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (clear_in) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + PTR_ONE;
      if (do_rd) rp <= rp + PTR_ONE;
      count <= count + (WAD+1)'(do_wr) - (WAD+1)'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !clear_in) mem[wp] <= wr_data;
  end

endmodule

// File: rtl/relm_uart.sv
// 8N1 UART for the ReLM CPU: FIFO-buffered receiver, single-byte holding
// register on transmit, and one registered status word on pop_q.
module relm_uart
  import relm_io_pkg::*;
#(
  parameter int WD  = 32,
  parameter int DIV = 434,
  parameter int WAD = 4
) (
  input  logic        clk,
  input  logic        rst_n_in,
  input  logic [WD:0] pop_d,
  output logic [WD:0] pop_q,
  input  logic        uart_in,
  output logic        uart_out
);

  localparam logic [15:0] BIT_END = 16'(DIV - 1);
  localparam logic [15:0] MID     = 16'(DIV / 2 - 1);

  logic tx_wr, rx_pop, err_clr;
  logic unused_pop_d;
  assign tx_wr        = pop_d[WD-CMD_TX_WR];
  assign rx_pop       = pop_d[WD-CMD_RX_POP];
  assign err_clr      = pop_d[WD-CMD_ERR_CLR];
  assign unused_pop_d = ^{pop_d[WD], pop_d[WD-4:8]};

  // synchronizer; prime marks when rx_s2 carries a real line sample after reset
  logic       rx_s1, rx_s2, armed;
  logic [1:0] prime;
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      prime <= 2'b00;
      armed <= 1'b0;
    end else begin
      rx_s1 <= uart_in;
      rx_s2 <= rx_s1;
      prime <= {prime[0], 1'b1};
      if (prime[1] && rx_s2) armed <= 1'b1;
    end
  end

  uart_st_e    rx_st;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_byte, fifo_head;
  logic        fifo_empty, fifo_full, stop_hit, fifo_wr, pop_ok, ovr_set, ferr_set;

  assign stop_hit = (rx_st == ST_STOP) && (rx_cnt == BIT_END);
  assign fifo_wr  = stop_hit && rx_s2;
  assign pop_ok   = rx_pop && !fifo_empty;
  assign ovr_set  = fifo_wr && fifo_full && !pop_ok;
  assign ferr_set = stop_hit && !rx_s2;

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_st  <= ST_IDLE;
      rx_cnt <= '0;
      rx_idx <= '0;
    end else begin
      case (rx_st)
        ST_IDLE: begin
          rx_cnt <= '0;
          rx_idx <= '0;
          if (armed && !rx_s2) rx_st <= ST_START;
        end
        ST_START: begin
          if (rx_cnt == MID) begin
            rx_cnt <= '0;
            rx_st  <= rx_s2 ? ST_IDLE : ST_DATA;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        ST_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            if (rx_idx == 3'd7) rx_st <= ST_STOP;
            else rx_idx <= rx_idx + 3'd1;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        default: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            rx_st  <= ST_IDLE;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_st == ST_DATA && rx_cnt == BIT_END) rx_byte[rx_idx] <= rx_s2;
  end

  relm_fifo #(.WAD(WAD), .WD(8)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n_in),
    .clear_in (1'b0),
    .wr_en    (fifo_wr),
    .wr_data  (rx_byte),
    .rd_en    (rx_pop),
    .rd_data  (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // a set event in the same cycle as a clear wins
  logic overrun, framing_error;
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      overrun       <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (ovr_set) overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
      if (ferr_set) framing_error <= 1'b1;
      else if (err_clr) framing_error <= 1'b0;
    end
  end

  uart_st_e    tx_st;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  hold_data, tx_shift;
  logic        hold_full, hold_full_nxt, tx_take, tx_bit_end;

  assign tx_bit_end = (tx_cnt == BIT_END);
  // the holding register drains at idle or right at the end of a stop bit
  assign tx_take = hold_full && ((tx_st == ST_IDLE) || (tx_st == ST_STOP && tx_bit_end));

  always_comb begin
    hold_full_nxt = hold_full;
    if (tx_take) hold_full_nxt = 1'b0;
    else if (tx_wr && !hold_full) hold_full_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (tx_wr && !hold_full) hold_data <= pop_d[7:0];
    if (tx_take) tx_shift <= hold_data;
    else if (tx_st == ST_DATA && tx_bit_end) tx_shift <= tx_shift >> 1;
  end

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_st     <= ST_IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      uart_out  <= 1'b1;
      hold_full <= 1'b0;
    end else begin
      hold_full <= hold_full_nxt;
      case (tx_st)
        ST_IDLE: begin
          tx_cnt <= '0;
          tx_idx <= '0;
          if (tx_take) begin
            tx_st    <= ST_START;
            uart_out <= 1'b0;
          end
        end
        ST_START: begin
          if (tx_bit_end) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_st    <= ST_DATA;
            uart_out <= tx_shift[0];
          end else tx_cnt <= tx_cnt + 16'd1;
        end
        ST_DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_idx == 3'd7) begin
              tx_st    <= ST_STOP;
              uart_out <= 1'b1;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              uart_out <= tx_shift[1];
            end
          end else tx_cnt <= tx_cnt + 16'd1;
        end
        default: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_take) begin
              tx_st    <= ST_START;
              uart_out <= 1'b0;
            end else tx_st <= ST_IDLE;
          end else tx_cnt <= tx_cnt + 16'd1;
        end
      endcase
    end
  end

  // tx_ready follows the holding register as it stands after this edge
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pop_q                 <= '0;
      pop_q[WD-STS_TX_RDY]  <= 1'b1;
    end else begin
      pop_q                 <= '0;
      pop_q[WD-STS_TX_RDY]  <= !hold_full_nxt;
      pop_q[WD-STS_RX_VLD]  <= !fifo_empty;
      pop_q[WD-STS_OVR]     <= overrun;
      pop_q[WD-STS_FERR]    <= framing_error;
      pop_q[7:0]            <= fifo_empty ? 8'h00 : fifo_head;
    end
  end

endmodule

// File: tb/tb_relm_uart.sv
// Randomized bench for relm_uart: bytes are framed onto uart_in and the TX line
// is captured, both compared against a queue-based model of the status word.
module tb_relm_uart;
  localparam int WD = 32, DIV = 8, WAD = 2, DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n_in;
  logic [WD:0] pop_d, pop_q;
  logic        uart_in, uart_out;

  int total = 0, bad = 0, cyc = 0;
  logic [7:0] mq[$];
  logic       m_ovr, m_ferr;
  logic [7:0] tx_bytes[4];

  relm_uart #(.WD(WD), .DIV(DIV), .WAD(WAD)) dut (
    .clk(clk), .rst_n_in(rst_n_in), .pop_d(pop_d), .pop_q(pop_q),
    .uart_in(uart_in), .uart_out(uart_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [WD:0] exp_status();
    logic [WD:0] s;
    s = '0;
    s[WD-1] = 1'b1;
    s[WD-2] = (mq.size() != 0);
    s[WD-3] = m_ovr;
    s[WD-4] = m_ferr;
    if (mq.size() != 0) s[7:0] = mq[0];
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
  endtask

  // frame a byte onto the line and apply the receive rules to the model
  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_in = 1'b0; tick(DIV);
    for (int i = 0; i < 8; i++) begin uart_in = b[i]; tick(DIV); end
    uart_in = stop; tick(DIV);
    uart_in = 1'b1; tick(6);
    if (!stop) m_ferr = 1'b1;
    else if (mq.size() == DEPTH) m_ovr = 1'b1;
    else mq.push_back(b);
  endtask

  task automatic pop_one();
    pop_d[WD-2] = 1'b1; tick(1);
    pop_d = '0; tick(1);
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic err_clear();
    pop_d[WD-3] = 1'b1; tick(1);
    pop_d = '0; tick(1);
    m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; pop_d = '0; uart_in = 1'b1;
    model_reset();
    tick(3);
    total++; if (uart_out !== 1'b1) begin bad++; $display("FAIL reset_uart_out got=%b want=1", uart_out); end
    total++; if (pop_q !== exp_status()) begin bad++; $display("FAIL reset_status got=%h want=%h", pop_q, exp_status()); end
    rst_n_in = 1'b1; tick(4);
    total++; if (pop_q !== exp_status()) begin bad++; $display("FAIL post_reset_status got=%h want=%h", pop_q, exp_status()); end
  endtask

  task automatic test_rx_basic();
    send_byte(8'h5A, 1'b1);
    total++; if (pop_q !== exp_status()) begin bad++; $display("FAIL rx_5a got=%h want=%h", pop_q, exp_status()); end
    pop_one();
    total++; if (pop_q !== exp_status()) begin bad++; $display("FAIL rx_5a_pop got=%h want=%h", pop_q, exp_status()); end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    total++; if (pop_q !== exp_status()) begin bad++; $display("FAIL overrun_set got=%h want=%h", pop_q, exp_status()); end
    err_clear();
    total++; if (pop_q !== exp_status()) begin bad++; $display("FAIL overrun_clear got=%h want=%h", pop_q, exp_status()); end
    for (int i = 0; i < 4; i++) begin
      pop_one();
      total++; if (pop_q !== exp_status()) begin bad++; $display("FAIL overrun_drain%0d got=%h want=%h", i, pop_q, exp_status()); end
    end
  endtask

  task automatic test_framing();
    send_byte(8'hA5, 1'b0);
    total++; if (pop_q !== exp_status()) begin bad++; $display("FAIL framing_set got=%h want=%h", pop_q, exp_status()); end
    tick(DIV * 2);
    send_byte(8'h3C, 1'b1);
    total++; if (pop_q !== exp_status()) begin bad++; $display("FAIL framing_next got=%h want=%h", pop_q, exp_status()); end
    pop_one(); err_clear();
    total++; if (pop_q !== exp_status()) begin bad++; $display("FAIL framing_clear got=%h want=%h", pop_q, exp_status()); end
  endtask

  task automatic test_glitch();
    uart_in = 1'b0; tick(3);
    uart_in = 1'b1; tick(DIV * 12);
    total++; if (pop_q !== exp_status()) begin bad++; $display("FAIL glitch got=%h want=%h", pop_q, exp_status()); end
  endtask

  task automatic run_tx(input int n);
    logic cap [0:399];
    int   acc [4];
    int   cyc0, s;
    cyc0 = 0;
    fork
      begin
        for (int i = 0; i < n * 80 + 40; i++) begin
          @(negedge clk);
          if (i == 0) cyc0 = cyc;
          cap[i] = uart_out;
        end
      end
      begin
        for (int j = 0; j < n; j++) begin
          int w;
          w = 0;
          while (pop_q[WD-1] !== 1'b1 && w < 300) begin @(negedge clk); w++; end
          total++; if (w >= 300) begin bad++; $display("FAIL tx_ready_wait byte=%0d waited=%0d want<300", j, w); end
          pop_d[WD-1] = 1'b1; pop_d[7:0] = tx_bytes[j]; acc[j] = cyc;
          @(negedge clk);
          pop_d = '0;
        end
      end
    join
    s = -1;
    for (int i = 0; i < 40; i++) if (s < 0 && cap[i] === 1'b0) s = i;
    total++;
    if (s < 0) begin bad++; $display("FAIL tx_start got=none want=start bit within 40 cycles"); end
    else begin
      for (int b = 0; b < n * 10; b++) begin
        int f, k;
        logic e, ok;
        f = b / 10; k = b % 10;
        e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : tx_bytes[f][k-1];
        ok = 1'b1;
        for (int c = 0; c < DIV; c++) if (cap[s + b * DIV + c] !== e) ok = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL tx_bit frame=%0d bit=%0d got=%b want=%b", f, k, cap[s + b * DIV + DIV/2], e); end
      end
      for (int j = 1; j < n; j++) begin
        total++; if (acc[j] >= cyc0 + s + 80 * j) begin bad++; $display("FAIL tx_refill byte=%0d got=cycle %0d want<%0d", j, acc[j], cyc0 + s + 80 * j); end
      end
      begin
        logic idle_ok;
        idle_ok = 1'b1;
        for (int c = 0; c < 16; c++) if (cap[s + n * 80 + c] !== 1'b1) idle_ok = 1'b0;
        total++; if (!idle_ok) begin bad++; $display("FAIL tx_idle got=low want=high after %0d frames", n); end
      end
    end
  endtask

  task automatic test_tx_back_to_back();
    tx_bytes[0] = 8'h55; tx_bytes[1] = 8'hAA;
    run_tx(2);
    for (int i = 0; i < 3; i++) tx_bytes[i] = 8'($urandom);
    run_tx(3);
  endtask

  task automatic test_tx_and_pop();
    send_byte(8'($urandom), 1'b1);
    pop_d[WD-1] = 1'b1; pop_d[WD-2] = 1'b1; pop_d[7:0] = 8'($urandom);
    tick(1);
    pop_d = '0;
    total++; if (pop_q[WD-1] !== 1'b0) begin bad++; $display("FAIL tx_ready_after_write got=%b want=0", pop_q[WD-1]); end
    tick(1);
    void'(mq.pop_front());
    total++; if (pop_q !== exp_status()) begin bad++; $display("FAIL tx_pop_status got=%h want=%h", pop_q, exp_status()); end
    total++; if (uart_out !== 1'b0) begin bad++; $display("FAIL tx_pop_start got=%b want=0", uart_out); end
    tick(DIV * 11);
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      logic [7:0] b;
      logic stop;
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_byte(b, stop);
      total++; if (pop_q !== exp_status()) begin bad++; $display("FAIL rand_rx it=%0d got=%h want=%h", it, pop_q, exp_status()); end
      if ($urandom_range(0, 1) == 1) begin
        pop_one();
        total++; if (pop_q !== exp_status()) begin bad++; $display("FAIL rand_pop it=%0d got=%h want=%h", it, pop_q, exp_status()); end
      end
      if ($urandom_range(0, 3) == 0) begin
        err_clear();
        total++; if (pop_q !== exp_status()) begin bad++; $display("FAIL rand_clr it=%0d got=%h want=%h", it, pop_q, exp_status()); end
      end
    end
    while (mq.size() != 0) pop_one();
    err_clear();
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h81, 1'b1);
    pop_d[WD-1] = 1'b1; pop_d[7:0] = 8'h00;
    tick(1);
    pop_d = '0;
    tick(30);
    total++; if (uart_out !== 1'b0) begin bad++; $display("FAIL mid_frame_line got=%b want=0", uart_out); end
    rst_n_in = 1'b0;
    model_reset();
    #1;
    total++; if (uart_out !== 1'b1) begin bad++; $display("FAIL reset_mid_tx_line got=%b want=1", uart_out); end
    total++; if (pop_q !== exp_status()) begin bad++; $display("FAIL reset_mid_tx_status got=%h want=%h", pop_q, exp_status()); end
    tick(2);
    rst_n_in = 1'b1;
    tick(4);
  endtask

  task automatic test_reset_line_low();
    uart_in = 1'b0;
    rst_n_in = 1'b0; tick(2);
    rst_n_in = 1'b1; tick(20);
    uart_in = 1'b1; tick(DIV * 12);
    total++; if (pop_q !== exp_status()) begin bad++; $display("FAIL line_low_after_reset got=%h want=%h", pop_q, exp_status()); end
    send_byte(8'hC3, 1'b1);
    total++; if (pop_q !== exp_status()) begin bad++; $display("FAIL rx_after_reset got=%h want=%h", pop_q, exp_status()); end
    pop_one();
  endtask

  initial begin
    rst_n_in = 1'b0; pop_d = '0; uart_in = 1'b1;
    test_reset();
    test_rx_basic();
    test_overrun();
    test_framing();
    test_glitch();
    test_tx_back_to_back();
    test_tx_and_pop();
    test_random();
    test_reset_mid_frame();
    test_reset_line_low();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
